// File: rtl/multicycle_ctrl_hs.sv
// Multicycle MIPS-subset control FSM with a req/ready memory handshake, bounded wait and sticky trap.
// Optional feature macro: MULTI_CTRL_PERF_EN adds perf_cycles/perf_instrs counters.
module multicycle_ctrl_hs #(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            i_or_d,
  output logic [1:0]      pc_src,
  output logic            pc_write,
  output logic            branch,
  output logic            branch_ne,
  output logic            ireg_enab,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_srcA,
  output logic [1:0]      alu_srcB,
  output logic [2:0]      alu_op,
  output logic            zext,
  output logic            trap,
  output logic [1:0]      trap_code
`ifdef MULTI_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_instrs
`endif
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEM_ADDR   = 4'd2,
    S_MEM_READ   = 4'd3,
    S_MEM_WRITE  = 4'd4,
    S_MEM_TO_REG = 4'd5,
    S_EXECUTE    = 4'd6,
    S_ALU_TO_REG = 4'd7,
    S_IMM_EXEC   = 4'd8,
    S_IMM_TO_REG = 4'd9,
    S_BRANCH     = 4'd10,
    S_JUMP       = 4'd11,
    S_TRAP       = 4'd12
  } state_t;

  // fetch/jump are raw state flags; mem_ready gating of ireg_enab/pc_write happens at the port.
  typedef struct packed {
    logic       mem_req, mem_we, i_or_d;
    logic [1:0] pc_src;
    logic       jump, fetch, branch, branch_ne;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       zext, trap;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [OP_W-1:0] opr);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:      begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:     c.alu_src_b = 2'b11;
      S_MEM_ADDR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_READ:   begin c.mem_req = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WRITE:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_TO_REG: begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_EXECUTE:    begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
      S_ALU_TO_REG: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_IMM_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.zext      = 1'b1;
        c.alu_op    = (opr == OP_ORI) ? 3'b100 : 3'b011;
      end
      S_IMM_TO_REG: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b001;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
        c.branch_ne = (opr == OP_BNE);
      end
      S_JUMP:       begin c.pc_src = 2'b10; c.jump = 1'b1; end
      S_TRAP:       c.trap = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

  state_t            state_reg, state_next;
  logic [OP_W-1:0]   op_reg, op_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
  logic [1:0]        trap_code_reg, trap_code_next;
  logic              run_reg;
  logic              mem_state;
  ctrl_t             ctrl_reg;

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    wait_cnt_next  = '0;
    trap_code_next = trap_code_reg;
    wait_cnt_inc   = wait_cnt_reg + CNT_W'(1);
    mem_state      = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                     (state_reg == S_MEM_WRITE);
    // run_reg holds the FSM in FETCH for the cycle that straddles reset release.
    if (run_reg) begin
      case (state_reg)
        S_FETCH:      if (mem_ready) state_next = S_DECODE;
        S_DECODE: begin
          op_next = op;
          case (op)
            OP_RTYPE:                 state_next = S_EXECUTE;
            OP_LW, OP_SW, OP_ADDI:    state_next = S_MEM_ADDR;
            OP_ANDI, OP_ORI:          state_next = S_IMM_EXEC;
            OP_BEQ, OP_BNE:           state_next = S_BRANCH;
            OP_J:                     state_next = S_JUMP;
            default: begin
              state_next     = S_TRAP;
              trap_code_next = 2'b01;
            end
          endcase
        end
        S_MEM_ADDR: begin
          if (op_reg == OP_LW)        state_next = S_MEM_READ;
          else if (op_reg == OP_SW)   state_next = S_MEM_WRITE;
          else if (op_reg == OP_ADDI) state_next = S_IMM_TO_REG;
          else begin
            state_next     = S_TRAP;
            trap_code_next = 2'b01;
          end
        end
        S_MEM_READ:   if (mem_ready) state_next = S_MEM_TO_REG;
        S_MEM_WRITE:  if (mem_ready) state_next = S_FETCH;
        S_MEM_TO_REG: state_next = S_FETCH;
        S_EXECUTE:    state_next = S_ALU_TO_REG;
        S_ALU_TO_REG: state_next = S_FETCH;
        S_IMM_EXEC:   state_next = S_IMM_TO_REG;
        S_IMM_TO_REG: state_next = S_FETCH;
        S_BRANCH:     state_next = S_FETCH;
        S_JUMP:       state_next = S_FETCH;
        S_TRAP:       state_next = S_TRAP;
        default: begin
          state_next     = S_TRAP;
          trap_code_next = 2'b01;
        end
      endcase
      // The wait that would push the counter to TIMEOUT traps; ready on that cycle still succeeds.
      if (mem_state && !mem_ready) begin
        if (wait_cnt_inc == CNT_W'(TIMEOUT)) begin
          state_next     = S_TRAP;
          trap_code_next = 2'b10;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_FETCH;
      op_reg        <= '0;
      wait_cnt_reg  <= '0;
      trap_code_reg <= 2'b00;
      run_reg       <= 1'b0;
      ctrl_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      wait_cnt_reg  <= wait_cnt_next;
      trap_code_reg <= trap_code_next;
      run_reg       <= 1'b1;
      ctrl_reg      <= decode_ctrl(state_next, op_next);
    end
  end

  assign mem_req    = ctrl_reg.mem_req;
  assign mem_we     = ctrl_reg.mem_we;
  assign i_or_d     = ctrl_reg.i_or_d;
  assign pc_src     = ctrl_reg.pc_src;
  assign pc_write   = ctrl_reg.jump | (ctrl_reg.fetch & mem_ready);
  assign branch     = ctrl_reg.branch;
  assign branch_ne  = ctrl_reg.branch_ne;
  assign ireg_enab  = ctrl_reg.fetch & mem_ready;
  assign reg_dst    = ctrl_reg.reg_dst;
  assign mem_to_reg = ctrl_reg.mem_to_reg;
  assign reg_write  = ctrl_reg.reg_write;
  assign alu_srcA   = ctrl_reg.alu_src_a;
  assign alu_srcB   = ctrl_reg.alu_src_b;
  assign alu_op     = ctrl_reg.alu_op;
  assign zext       = ctrl_reg.zext;
  assign trap       = ctrl_reg.trap;
  assign trap_code  = trap_code_reg;

`ifdef MULTI_CTRL_PERF_EN
  logic [31:0] perf_cycles_reg, perf_instrs_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles_reg <= '0;
      perf_instrs_reg <= '0;
    end else begin
      if (run_reg && (state_reg != S_TRAP))
        perf_cycles_reg <= perf_cycles_reg + 32'd1;
      if (run_reg && (state_next == S_FETCH) && (state_reg != S_FETCH))
        perf_instrs_reg <= perf_instrs_reg + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_reg;
  assign perf_instrs = perf_instrs_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Directed testbench for multicycle_ctrl_hs: per-cycle expected outputs are queued with the stimulus
// and popped/compared on the falling edge.
module tb_multicycle_ctrl_hs;
  localparam int OP_W = 6;

  localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_MEM_ADDR = 3, T_MEM_READ = 4;
  localparam int T_MEM_WRITE = 5, T_MEM_TO_REG = 6, T_EXECUTE = 7, T_ALU_TO_REG = 8;
  localparam int T_IMM_EXEC = 9, T_IMM_TO_REG = 10, T_BRANCH = 11, T_JUMP = 12, T_TRAP = 13;

  logic            clk;
  logic            reset_n;
  logic [OP_W-1:0] op;
  logic            mem_ready;
  logic            mem_req, mem_we, i_or_d, pc_write, branch, branch_ne, ireg_enab;
  logic            reg_dst, mem_to_reg, reg_write, alu_srcA, zext, trap;
  logic [1:0]      pc_src, alu_srcB, trap_code;
  logic [2:0]      alu_op;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d;
    logic [1:0] pc_src;
    logic       pc_write, branch, branch_ne, ireg_enab;
    logic       reg_dst, mem_to_reg, reg_write, alu_srcA;
    logic [1:0] alu_srcB;
    logic [2:0] alu_op;
    logic       zext, trap;
    logic [1:0] trap_code;
  } outs_t;

  outs_t obs;
  outs_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  multicycle_ctrl_hs #(.OP_W(OP_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .pc_src(pc_src),
    .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne), .ireg_enab(ireg_enab),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_op(alu_op), .zext(zext),
    .trap(trap), .trap_code(trap_code)
  );

  assign obs = {mem_req, mem_we, i_or_d, pc_src, pc_write, branch, branch_ne, ireg_enab,
                reg_dst, mem_to_reg, reg_write, alu_srcA, alu_srcB, alu_op, zext, trap,
                trap_code};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle, written straight from the state table.
  function automatic outs_t model(input int st, input logic rdy, input logic flag,
                                  input logic [1:0] code);
    outs_t e;
    e = '0;
    e.trap_code = code;
    case (st)
      T_FETCH: begin
        e.mem_req = 1'b1; e.alu_srcB = 2'b01; e.ireg_enab = rdy; e.pc_write = rdy;
      end
      T_DECODE:     e.alu_srcB = 2'b11;
      T_MEM_ADDR:   begin e.alu_srcA = 1'b1; e.alu_srcB = 2'b10; end
      T_MEM_READ:   begin e.mem_req = 1'b1; e.i_or_d = 1'b1; end
      T_MEM_WRITE:  begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.i_or_d = 1'b1; end
      T_MEM_TO_REG: begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      T_EXECUTE:    begin e.alu_srcA = 1'b1; e.alu_op = 3'b010; end
      T_ALU_TO_REG: begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      T_IMM_EXEC: begin
        e.alu_srcA = 1'b1; e.alu_srcB = 2'b10; e.zext = 1'b1;
        e.alu_op = flag ? 3'b100 : 3'b011;
      end
      T_IMM_TO_REG: e.reg_write = 1'b1;
      T_BRANCH: begin
        e.alu_srcA = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.branch = 1'b1;
        e.branch_ne = flag;
      end
      T_JUMP:       begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      T_TRAP:       e.trap = 1'b1;
      default:      e.trap_code = 2'b00;
    endcase
    return e;
  endfunction

  task automatic cyc(input int st, input logic rdy, input logic flag, input logic [1:0] code,
                     input string tag);
    mem_ready = rdy;
    exp_q.push_back(model(st, rdy, flag, code));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [OP_W-1:0] opc, input string name);
    op = opc;
    $display("txn %s op=%b", name, opc);
    cyc(T_FETCH, 1'b1, 1'b0, 2'b00, {name, ".fetch"});
    cyc(T_DECODE, 1'b0, 1'b0, 2'b00, {name, ".decode"});
  endtask

  initial begin
    reset_n   = 1'b0;
    op        = '0;
    mem_ready = 1'b0;

    fork
      forever begin : checker_loop
        outs_t e;
        string t;
        @(negedge clk);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          checks++;
          assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
          end
        end
      end
    join_none

    @(posedge clk);
    #1;
    $display("txn reset");
    cyc(T_RST, 1'b0, 1'b0, 2'b00, "reset0");
    cyc(T_RST, 1'b1, 1'b0, 2'b00, "reset1");
    reset_n = 1'b1;
    cyc(T_RST, 1'b1, 1'b0, 2'b00, "rst_release");

    fetch_decode(6'b001000, "addi");
    cyc(T_MEM_ADDR, 1'b1, 1'b0, 2'b00, "addi.mem_addr");
    cyc(T_IMM_TO_REG, 1'b1, 1'b0, 2'b00, "addi.imm_to_reg");

    fetch_decode(6'b001101, "ori");
    cyc(T_IMM_EXEC, 1'b1, 1'b1, 2'b00, "ori.imm_exec");
    cyc(T_IMM_TO_REG, 1'b0, 1'b0, 2'b00, "ori.imm_to_reg");

    fetch_decode(6'b001100, "andi");
    cyc(T_IMM_EXEC, 1'b0, 1'b0, 2'b00, "andi.imm_exec");
    cyc(T_IMM_TO_REG, 1'b1, 1'b0, 2'b00, "andi.imm_to_reg");

    fetch_decode(6'b000101, "bne");
    cyc(T_BRANCH, 1'b1, 1'b1, 2'b00, "bne.branch");

    fetch_decode(6'b000100, "beq");
    cyc(T_BRANCH, 1'b0, 1'b0, 2'b00, "beq.branch");

    fetch_decode(6'b000000, "rtype");
    cyc(T_EXECUTE, 1'b1, 1'b0, 2'b00, "rtype.execute");
    cyc(T_ALU_TO_REG, 1'b0, 1'b0, 2'b00, "rtype.alu_to_reg");

    fetch_decode(6'b000010, "j");
    cyc(T_JUMP, 1'b0, 1'b0, 2'b00, "j.jump");

    fetch_decode(6'b101011, "sw_wait1");
    cyc(T_MEM_ADDR, 1'b0, 1'b0, 2'b00, "sw.mem_addr");
    cyc(T_MEM_WRITE, 1'b0, 1'b0, 2'b00, "sw.mem_write_wait");
    cyc(T_MEM_WRITE, 1'b1, 1'b0, 2'b00, "sw.mem_write_done");

    fetch_decode(6'b100011, "lw_wait3");
    cyc(T_MEM_ADDR, 1'b0, 1'b0, 2'b00, "lw.mem_addr");
    for (int i = 0; i < 3; i++) cyc(T_MEM_READ, 1'b0, 1'b0, 2'b00, "lw.mem_read_wait");
    cyc(T_MEM_READ, 1'b1, 1'b0, 2'b00, "lw.mem_read_done");
    cyc(T_MEM_TO_REG, 1'b0, 1'b0, 2'b00, "lw.mem_to_reg");

    op = 6'b000010;
    $display("txn fetch_wait15_then_ready");
    for (int i = 0; i < 15; i++) cyc(T_FETCH, 1'b0, 1'b0, 2'b00, "w15.fetch_wait");
    cyc(T_FETCH, 1'b1, 1'b0, 2'b00, "w15.fetch_ready_at_limit");
    cyc(T_DECODE, 1'b0, 1'b0, 2'b00, "w15.decode");
    cyc(T_JUMP, 1'b0, 1'b0, 2'b00, "w15.jump");

    fetch_decode(6'b100011, "lw_reset_mid");
    cyc(T_MEM_ADDR, 1'b0, 1'b0, 2'b00, "lwr.mem_addr");
    cyc(T_MEM_READ, 1'b0, 1'b0, 2'b00, "lwr.mem_read");
    reset_n = 1'b0;
    cyc(T_RST, 1'b1, 1'b0, 2'b00, "lwr.in_reset");
    reset_n = 1'b1;
    cyc(T_RST, 1'b1, 1'b0, 2'b00, "lwr.release");
    fetch_decode(6'b000010, "j_after_reset");
    cyc(T_JUMP, 1'b1, 1'b0, 2'b00, "jar.jump");

    fetch_decode(6'b111111, "illegal");
    cyc(T_TRAP, 1'b1, 1'b0, 2'b01, "ill.trap0");
    cyc(T_TRAP, 1'b0, 1'b0, 2'b01, "ill.trap1");
    cyc(T_TRAP, 1'b1, 1'b0, 2'b01, "ill.trap2");
    cyc(T_TRAP, 1'b1, 1'b0, 2'b01, "ill.trap3");

    reset_n = 1'b0;
    $display("txn reset_before_timeout");
    cyc(T_RST, 1'b0, 1'b0, 2'b00, "to.in_reset");
    reset_n = 1'b1;
    cyc(T_RST, 1'b0, 1'b0, 2'b00, "to.release");
    op = 6'b000010;
    $display("txn fetch_timeout");
    for (int i = 0; i < 16; i++) cyc(T_FETCH, 1'b0, 1'b0, 2'b00, "to.fetch_wait");
    cyc(T_TRAP, 1'b1, 1'b0, 2'b10, "to.trap0");
    cyc(T_TRAP, 1'b1, 1'b0, 2'b10, "to.trap1");
    cyc(T_TRAP, 1'b0, 1'b0, 2'b10, "to.trap2");

    @(negedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
